// File: rtl/permutation_round_engine.sv
// Iterative ASCON permutation: pC and pL here, external S-box layer on sub_o/sub_i; one round per clock.
// Latency: n RUN cycles after the accepted start, then a one-cycle valid_o pulse in DONE.
// Backpressure: none; start_i is only honoured in IDLE and is dropped while a job is running.
module permutation_round_engine #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [3:0]       rounds_i,
  input  logic [4:0][63:0] state_i,
  output logic [4:0][63:0] sub_o,
  input  logic [4:0][63:0] sub_i,
  output logic [4:0][63:0] state_o,
  output logic             busy_o,
  output logic             valid_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  logic [1:0]       fsm_q;
  logic [3:0]       round_q;
  logic [4:0][63:0] state_q;
  logic [4:0][63:0] lin;
  logic [3:0]       n_rounds;
  logic [7:0]       rc;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned s);
    return (x >> s) | (x << (64 - s));
  endfunction

  always_comb begin
    n_rounds = rounds_i;
    if (rounds_i == 4'd0 || rounds_i > MAX_R) n_rounds = MAX_R;
  end

  // Constant only injected while running, so sub_o reads as zero out of reset.
  always_comb begin
    rc = {4'hF - round_q, round_q};
    sub_o = state_q;
    if (fsm_q == RUN) sub_o[2][7:0] = state_q[2][7:0] ^ rc;
  end

  always_comb begin
    lin[0] = sub_i[0] ^ rotr(sub_i[0], 19) ^ rotr(sub_i[0], 28);
    lin[1] = sub_i[1] ^ rotr(sub_i[1], 61) ^ rotr(sub_i[1], 39);
    lin[2] = sub_i[2] ^ rotr(sub_i[2], 1)  ^ rotr(sub_i[2], 6);
    lin[3] = sub_i[3] ^ rotr(sub_i[3], 10) ^ rotr(sub_i[3], 17);
    lin[4] = sub_i[4] ^ rotr(sub_i[4], 7)  ^ rotr(sub_i[4], 41);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            round_q <= MAX_R - n_rounds;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= lin;
          round_q <= round_q + 4'd1;
          if (round_q == MAX_R - 4'd1) fsm_q <= DONE;
        end
        DONE:    fsm_q <= IDLE;
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign busy_o  = (fsm_q == RUN);
  assign valid_o = (fsm_q == DONE);

endmodule

// File: tb/tb_permutation_round_engine.sv
// Directed and randomised jobs against a bench-side ASCON reference (own S-box, constant table, bitwise rotate).
// The bench supplies the S-box layer, or a wire bypass for hand-computed vectors.
module tb_permutation_round_engine;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       rounds;
  logic [4:0][63:0] state_in;
  logic [4:0][63:0] sub_o;
  logic [4:0][63:0] sub_ret;
  logic [4:0][63:0] state_o;
  logic             busy;
  logic             valid;
  logic             bypass;

  int n_chk  = 0;
  int n_pass = 0;

  int               busy_cnt;
  int               valid_cnt;
  logic [63:0]      first_x2;
  logic [7:0]       last_rc;
  logic [4:0][63:0] job_out;

  always #5 clk = ~clk;

  permutation_round_engine #(.MAX_ROUNDS(12)) dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .start_i  (start),
    .rounds_i (rounds),
    .state_i  (state_in),
    .sub_o    (sub_o),
    .sub_i    (sub_ret),
    .state_o  (state_o),
    .busy_o   (busy),
    .valid_o  (valid)
  );

  function automatic logic [4:0][63:0] bench_sbox(input logic [4:0][63:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [4:0][63:0] r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
    return r;
  endfunction

  assign sub_ret = bypass ? sub_o : bench_sbox(sub_o);

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int b = 0; b < 64; b++) y[b] = x[(b + n) % 64];
    return y;
  endfunction

  function automatic logic [7:0] rc_tab(input int i);
    case (i)
      0: return 8'hF0;  1: return 8'hE1;  2: return 8'hD2;  3: return 8'hC3;
      4: return 8'hB4;  5: return 8'hA5;  6: return 8'h96;  7: return 8'h87;
      8: return 8'h78;  9: return 8'h69; 10: return 8'h5A; 11: return 8'h4B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [4:0][63:0] model_perm(input logic [4:0][63:0] s, input int n);
    logic [4:0][63:0] t;
    t = s;
    for (int i = 12 - n; i < 12; i++) begin
      t[2][7:0] = t[2][7:0] ^ rc_tab(i);
      t = bench_sbox(t);
      t[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
      t[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
      t[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
      t[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
      t[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [4:0][63:0] rand_state();
    logic [4:0][63:0] s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  // Runs one job; optionally pulses start during RUN cycle number 'poke'.
  task automatic run_job(input logic [4:0][63:0] s, input logic [3:0] nr, input int poke);
    bit seen;
    seen      = 1'b0;
    busy_cnt  = 0;
    valid_cnt = 0;
    @(negedge clk);
    start = 1'b1; state_in = s; rounds = nr;
    @(negedge clk);
    start = 1'b0; state_in = ~s; rounds = 4'd3;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      if (busy) begin
        busy_cnt++;
        if (busy_cnt == 1) first_x2 = sub_o[2];
        last_rc = sub_o[2][7:0] ^ state_o[2][7:0];
      end
      if (valid) begin
        valid_cnt++;
        job_out = state_o;
        seen = 1'b1;
      end
      if (!seen) begin
        start = (poke != 0 && busy_cnt == poke);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("job_done", 320'(seen), 320'(1));
    @(negedge clk);
    chk("valid_single", 320'(valid), 320'(0));
    chk("idle_after", 320'(busy), 320'(0));
    chk("state_hold", state_o, job_out);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0][63:0] s;
    logic [4:0][63:0] exp;
    int nr;
    int extra_busy;
    int stray_valid;

    rst_n = 1'b0; start = 1'b0; rounds = 4'd0; state_in = '0; bypass = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 320'(0));
    chk("rst_sub", sub_o, 320'(0));
    chk("rst_busy", 320'(busy), 320'(0));
    chk("rst_valid", 320'(valid), 320'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Zero state, full 12 rounds.
    run_job('0, 4'd12, 0);
    chk("t1_first_x2", 320'(first_x2), 320'(64'h00000000000000F0));
    chk("t1_busy", 320'(busy_cnt), 320'(12));
    chk("t1_valid", 320'(valid_cnt), 320'(1));

    // Six rounds: constants 0x96 .. 0x4B.
    run_job('0, 4'd6, 0);
    chk("t2_first_x2", 320'(first_x2), 320'(64'h0000000000000096));
    chk("t2_last_rc", 320'(last_rc), 320'(8'h4B));
    chk("t2_busy", 320'(busy_cnt), 320'(6));

    // One round runs the last round (constant 0x4B): x2 = pL(0x4A) with S-box bypassed.
    s = '0; s[2] = 64'h1;
    run_job(s, 4'd1, 0);
    exp = '0; exp[2] = 64'h280000000000006E;
    chk("t3_pl", job_out, exp);
    chk("t3_busy", 320'(busy_cnt), 320'(1));

    // Random full permutations through the bench S-box.
    bypass = 1'b0;
    for (int j = 0; j < 200; j++) begin
      s = rand_state();
      case ($urandom_range(0, 2))
        0:       nr = 6;
        1:       nr = 8;
        default: nr = 12;
      endcase
      run_job(s, 4'(nr), 0);
      chk("t4_perm", job_out, model_perm(s, nr));
      chk("t4_busy", 320'(busy_cnt), 320'(nr));
      chk("t4_valid", 320'(valid_cnt), 320'(1));
    end

    // start pulsed mid-run is ignored.
    s = rand_state();
    run_job(s, 4'd12, 4);
    chk("t5_perm", job_out, model_perm(s, 12));
    chk("t5_busy", 320'(busy_cnt), 320'(12));
    chk("t5_valid", 320'(valid_cnt), 320'(1));
    extra_busy = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy || valid) extra_busy++;
    end
    chk("t5_no_requeue", 320'(extra_busy), 320'(0));

    // Reset during round 5 of 12.
    s = rand_state();
    @(negedge clk);
    start = 1'b1; state_in = s; rounds = 4'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy_before", 320'(busy), 320'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_state_zero", state_o, 320'(0));
    chk("t6_sub_zero", sub_o, 320'(0));
    chk("t6_busy_zero", 320'(busy), 320'(0));
    stray_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid || busy) stray_valid++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (valid || busy) stray_valid++;
    end
    chk("t6_no_valid", 320'(stray_valid), 320'(0));
    chk("t6_state_after", state_o, 320'(0));
    s = rand_state();
    run_job(s, 4'd8, 0);
    chk("t6_new_job", job_out, model_perm(s, 8));

    // Out-of-range round counts run the full 12.
    s = rand_state();
    run_job(s, 4'd0, 0);
    chk("t7_r0_busy", 320'(busy_cnt), 320'(12));
    chk("t7_r0_perm", job_out, model_perm(s, 12));
    s = rand_state();
    run_job(s, 4'd15, 0);
    chk("t7_r15_busy", 320'(busy_cnt), 320'(12));
    chk("t7_r15_perm", job_out, model_perm(s, 12));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
